writeback_scoreboard: RTL and testbench

Writeback stage of the RISC-V core, and the single writer of the register file's write port. It takes completed ALU results and outstanding load responses, then drives the register file's write enable, destination and result one write per cycle. It also keeps a busy scoreboard that decode queries before reading rs1/rs2. Loads are held in an in-order queue until memory returns their data, which the block lane-selects and sign-/zero-extends.

---
 rtl/writeback_scoreboard.sv | 168 ++++++++++++++++
 tb/tb_writeback_scoreboard.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_scoreboard.sv
// Writeback stage and sole register-file writer: in-order load queue, one-entry ALU skid buffer, busy scoreboard.
// Optional WB_BYPASS_EN: a source being written this cycle reads as not busy (same-cycle operand bypass).
module writeback_scoreboard #(
  parameter int LQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic        issue_is_load,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_alu_result,
  input  logic [2:0]  issue_funct3,
  input  logic [1:0]  issue_byte_off,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        write_en_3,
  output logic [4:0]  wb_rd,
  output logic [31:0] result,
  output logic        wb_err
);

  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  function automatic logic [31:0] sext8(input logic signed [7:0] b);
    logic signed [31:0] w;
    w = b;
    return w;
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] h);
    logic signed [31:0] w;
    w = h;
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return sext8(b);
      3'b001:  return sext16(h);
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  logic [4:0]       lq_rd  [LQ_DEPTH];
  logic [2:0]       lq_f3  [LQ_DEPTH];
  logic [1:0]       lq_off [LQ_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [31:0]      busy, busy_nxt;

  logic             skid_vld;
  logic [4:0]       skid_rd;
  logic [31:0]      skid_data;

  logic             lq_empty, lq_full;
  logic             accept, push, alu_acc, retire;
  logic [4:0]       head_rd;
  logic [31:0]      ld_data_p0;
  logic             wb_we_p0;
  logic [4:0]       wb_rd_p0;
  logic [31:0]      wb_data_p0;

  assign lq_empty = (count == '0);
  assign lq_full  = (count == CNT_W'(LQ_DEPTH));

  assign issue_ready = !skid_vld
                    && !(issue_is_load && lq_full)
                    && !((issue_rd != 5'd0) && busy[issue_rd]);

  assign accept  = issue_valid && issue_ready;
  assign push    = accept && issue_is_load;
  assign alu_acc = accept && !issue_is_load;
  assign retire  = mem_rvalid && !lq_empty;

  assign head_rd    = lq_rd[head];
  assign ld_data_p0 = load_extract(mem_rdata, lq_f3[head], lq_off[head]);

`ifdef WB_BYPASS_EN
  assign rs1_busy = (rs1_addr != 5'd0) && busy[rs1_addr] && !(write_en_3 && (wb_rd == rs1_addr));
  assign rs2_busy = (rs2_addr != 5'd0) && busy[rs2_addr] && !(write_en_3 && (wb_rd == rs2_addr));
`else
  // The register file only commits at the end of the write cycle, so that register still reads busy.
  assign rs1_busy = (rs1_addr != 5'd0) && (busy[rs1_addr] || (write_en_3 && (wb_rd == rs1_addr)));
  assign rs2_busy = (rs2_addr != 5'd0) && (busy[rs2_addr] || (write_en_3 && (wb_rd == rs2_addr)));
`endif

  // Writeback arbitration: load response, then skid buffer, then fresh ALU issue.
  always_comb begin
    busy_nxt   = busy;
    wb_we_p0   = 1'b0;
    wb_rd_p0   = wb_rd;
    wb_data_p0 = result;
    if (retire) begin
      busy_nxt[head_rd] = 1'b0;
      wb_rd_p0          = head_rd;
      wb_data_p0        = ld_data_p0;
      wb_we_p0          = (head_rd != 5'd0);
    end else if (skid_vld) begin
      busy_nxt[skid_rd] = 1'b0;
      wb_rd_p0          = skid_rd;
      wb_data_p0        = skid_data;
      wb_we_p0          = (skid_rd != 5'd0);
    end else if (alu_acc) begin
      wb_rd_p0          = issue_rd;
      wb_data_p0        = issue_alu_result;
      wb_we_p0          = (issue_rd != 5'd0);
    end
    if (push || (alu_acc && retire)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd[tail]  <= issue_rd;
      lq_f3[tail]  <= issue_funct3;
      lq_off[tail] <= issue_byte_off;
    end
    if (alu_acc && retire) begin
      skid_rd   <= issue_rd;
      skid_data <= issue_alu_result;
    end
  end

  // Register-file write stage boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      busy       <= '0;
      skid_vld   <= 1'b0;
      write_en_3 <= 1'b0;
      wb_rd      <= 5'd0;
      result     <= 32'd0;
      wb_err     <= 1'b0;
    end else begin
      if (push)   tail <= tail + PTR_W'(1);
      if (retire) head <= head + PTR_W'(1);
      case ({push, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      busy <= busy_nxt;
      if (alu_acc && retire)      skid_vld <= 1'b1;
      else if (!retire)           skid_vld <= 1'b0;
      write_en_3 <= wb_we_p0;
      wb_rd      <= wb_rd_p0;
      result     <= wb_data_p0;
      if (mem_rvalid && lq_empty) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Self-checking bench for writeback_scoreboard: directed steps then random traffic against a queue-based model.
module tb_writeback_scoreboard;
  localparam int LQ_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        issue_valid = 1'b0, issue_is_load = 1'b0;
  logic        issue_ready;
  logic [4:0]  issue_rd = '0;
  logic [31:0] issue_alu_result = '0;
  logic [2:0]  issue_funct3 = '0;
  logic [1:0]  issue_byte_off = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  rs1_addr = '0, rs2_addr = '0;
  logic        rs1_busy, rs2_busy;
  logic        write_en_3;
  logic [4:0]  wb_rd;
  logic [31:0] result;
  logic        wb_err;

  writeback_scoreboard #(.LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_is_load(issue_is_load),
    .issue_rd(issue_rd), .issue_alu_result(issue_alu_result), .issue_funct3(issue_funct3),
    .issue_byte_off(issue_byte_off), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .write_en_3(write_en_3), .wb_rd(wb_rd), .result(result), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [2:0] f3; logic [1:0] off; } ld_t;

  ld_t         m_lq[$];
  logic [4:0]  m_skid_rd[$];
  logic [31:0] m_skid_data[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_res = '0;
  logic        m_err = 1'b0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (m_lq[i]) if (m_lq[i].rd == r) return 1'b1;
    foreach (m_skid_rd[i]) if (m_skid_rd[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic src_busy(input logic [4:0] r);
`ifdef WB_BYPASS_EN
    return pending(r) && !(m_we && m_rd == r);
`else
    return pending(r) || (r != 5'd0 && m_we && m_rd == r);
`endif
  endfunction

  function automatic logic exp_ready(input logic ld, input logic [4:0] r);
    return (m_skid_rd.size() == 0) && !(ld && m_lq.size() == LQ_DEPTH) && !pending(r);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    int b, h;
    b = int'((w >> (8 * off)) & 32'hFF);
    h = int'((w >> (16 * off[1])) & 32'hFFFF);
    case (f3)
      3'd0:    return (b >= 128)   ? 32'(b - 256)   : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic step(input logic iv, input logic il, input logic [4:0] rd, input logic [31:0] alu,
                      input logic [2:0] f3, input logic [1:0] off, input logic mv,
                      input logic [31:0] md, input logic [4:0] r1, input logic [4:0] r2);
    logic rdy, ret;
    ld_t  e;
    @(negedge clk);
    issue_valid = iv; issue_is_load = il; issue_rd = rd; issue_alu_result = alu;
    issue_funct3 = f3; issue_byte_off = off; mem_rvalid = mv; mem_rdata = md;
    rs1_addr = r1; rs2_addr = r2;
    #1;
    rdy = exp_ready(il, rd);
    chk("issue_ready", 32'(issue_ready), 32'(rdy));
    chk("rs1_busy", 32'(rs1_busy), 32'(src_busy(r1)));
    chk("rs2_busy", 32'(rs2_busy), 32'(src_busy(r2)));
    @(posedge clk);
    ret = mv && (m_lq.size() > 0);
    if (mv && m_lq.size() == 0) m_err = 1'b1;
    m_we = 1'b0;
    if (ret) begin
      e = m_lq.pop_front();
      m_rd = e.rd; m_res = ref_load(md, e.f3, e.off); m_we = (e.rd != 5'd0);
      if (iv && rdy && !il) begin
        m_skid_rd.push_back(rd); m_skid_data.push_back(alu);
      end
    end else if (m_skid_rd.size() > 0) begin
      m_rd = m_skid_rd.pop_front(); m_res = m_skid_data.pop_front(); m_we = (m_rd != 5'd0);
    end else if (iv && rdy && !il) begin
      m_rd = rd; m_res = alu; m_we = (rd != 5'd0);
    end
    if (iv && rdy && il) begin
      e.rd = rd; e.f3 = f3; e.off = off;
      m_lq.push_back(e);
    end
    #1;
    chk("write_en_3", 32'(write_en_3), 32'(m_we));
    if (m_we) begin
      chk("wb_rd", 32'(wb_rd), 32'(m_rd));
      chk("result", result, m_res);
    end
    chk("wb_err", 32'(wb_err), 32'(m_err));
  endtask

  task automatic idle(input logic [4:0] r1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 32'd0, r1, 5'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    issue_valid = 1'b0; mem_rvalid = 1'b0; issue_is_load = 1'b0; issue_rd = '0;
    #1;
    m_lq.delete(); m_skid_rd.delete(); m_skid_data.delete();
    m_we = 1'b0; m_err = 1'b0;
    chk("rst_write_en_3", 32'(write_en_3), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_wb_err", 32'(wb_err), 32'd0);
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] md;

    // reset state and an idle scoreboard
    do_reset();
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      #1;
      chk("rst_rs1_busy", 32'(rs1_busy), 32'd0);
    end

    // ALU writeback one cycle after issue
    step(1, 0, 5'd5, 32'h1234_5678, 3'd0, 2'd0, 0, 32'd0, 5'd5, 5'd0);
    chk("alu_we", 32'(write_en_3), 32'd1);
    chk("alu_rd", 32'(wb_rd), 32'd5);
    chk("alu_result", result, 32'h1234_5678);
    idle(5'd5);

    // LB and LBU from byte lane 2, with busy tracking on rd 7
    step(1, 1, 5'd7, 32'd0, 3'b000, 2'd2, 0, 32'd0, 5'd7, 5'd0);
    idle(5'd7);
    chk("ld_busy", 32'(rs1_busy), 32'd1);
    step(0, 0, 5'd0, 32'd0, 3'd0, 2'd0, 1, 32'h0080_0000, 5'd7, 5'd0);
    chk("lb_result", result, 32'hFFFF_FF80);
    idle(5'd7);
    idle(5'd7);
    chk("ld_busy_clear", 32'(rs1_busy), 32'd0);
    step(1, 1, 5'd7, 32'd0, 3'b100, 2'd2, 0, 32'd0, 5'd7, 5'd0);
    step(0, 0, 5'd0, 32'd0, 3'd0, 2'd0, 1, 32'h0080_0000, 5'd7, 5'd0);
    chk("lbu_result", result, 32'h0000_0080);
    idle(5'd7);

    // fill the load queue; a 5th load stalls, an ALU issue to a free rd does not
    for (int i = 0; i < 4; i++) step(1, 1, 5'(10 + i), 32'd0, 3'b010, 2'd0, 0, 32'd0, 5'(10 + i), 5'd0);
    step(1, 1, 5'd14, 32'd0, 3'b010, 2'd0, 0, 32'd0, 5'd14, 5'd10);
    chk("lq_full_ready", 32'(issue_ready), 32'd0);
    step(1, 0, 5'd15, 32'hCAFE_0015, 3'd0, 2'd0, 0, 32'd0, 5'd0, 5'd0);
    chk("alu_when_full_rd", 32'(wb_rd), 32'd15);
    for (int i = 0; i < 4; i++) begin
      md = $urandom;
      step(0, 0, 5'd0, 32'd0, 3'd0, 2'd0, 1, md, 5'(10 + i), 5'd0);
      chk("lq_order_rd", 32'(wb_rd), 32'(10 + i));
      chk("lq_order_result", result, md);
    end
    idle(5'd0);

    // ALU issue colliding with a load response goes through the skid buffer
    step(1, 1, 5'd9, 32'd0, 3'b010, 2'd0, 0, 32'd0, 5'd0, 5'd0);
    step(1, 0, 5'd3, 32'hAAAA_0003, 3'd0, 2'd0, 1, 32'h0000_0099, 5'd3, 5'd9);
    chk("skid_first_rd", 32'(wb_rd), 32'd9);
    chk("skid_full_ready", 32'(issue_ready), 32'd0);
    step(1, 0, 5'd4, 32'hBBBB_0004, 3'd0, 2'd0, 0, 32'd0, 5'd3, 5'd0);
    chk("skid_drain_rd", 32'(wb_rd), 32'd3);
    chk("skid_drain_result", result, 32'hAAAA_0003);
    step(1, 0, 5'd4, 32'hBBBB_0004, 3'd0, 2'd0, 0, 32'd0, 5'd4, 5'd0);
    chk("after_skid_rd", 32'(wb_rd), 32'd4);
    idle(5'd0);

    // response with an empty queue is flagged and sticks
    step(0, 0, 5'd0, 32'd0, 3'd0, 2'd0, 1, 32'h5555_5555, 5'd0, 5'd0);
    chk("err_set", 32'(wb_err), 32'd1);
    chk("err_no_write", 32'(write_en_3), 32'd0);
    idle(5'd0);
    idle(5'd0);
    chk("err_sticky", 32'(wb_err), 32'd1);

    // reset with two loads pending discards them
    step(1, 1, 5'd20, 32'd0, 3'b010, 2'd0, 0, 32'd0, 5'd0, 5'd0);
    step(1, 1, 5'd21, 32'd0, 3'b010, 2'd0, 0, 32'd0, 5'd20, 5'd21);
    do_reset();
    rs1_addr = 5'd20; rs2_addr = 5'd21;
    #1;
    chk("rst_busy20", 32'(rs1_busy), 32'd0);
    chk("rst_busy21", 32'(rs2_busy), 32'd0);
    step(0, 0, 5'd0, 32'd0, 3'd0, 2'd0, 1, 32'h1111_1111, 5'd20, 5'd21);
    chk("rst_queue_empty_err", 32'(wb_err), 32'd1);
    do_reset();

    // x0 destinations never write and never read busy
    step(1, 0, 5'd0, 32'hDEAD_BEEF, 3'd0, 2'd0, 0, 32'd0, 5'd0, 5'd0);
    chk("x0_alu_we", 32'(write_en_3), 32'd0);
    step(1, 1, 5'd0, 32'd0, 3'b010, 2'd0, 0, 32'd0, 5'd0, 5'd0);
    idle(5'd0);
    chk("x0_busy", 32'(rs1_busy), 32'd0);
    step(0, 0, 5'd0, 32'd0, 3'd0, 2'd0, 1, 32'h7777_7777, 5'd0, 5'd0);
    chk("x0_load_we", 32'(write_en_3), 32'd0);
    chk("x0_load_popped", 32'(wb_err), 32'd0);
    idle(5'd0);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           (m_lq.size() > 0) && ($urandom_range(0, 1) == 1), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
